// File: rtl/apb_seq_ctrl.sv
// Command-memory driven APB master: fetches 3-word commands (CTL, ADR, DAT),
// runs them on an APB bus of NUM_SLAVES slaves, and writes read data back to memory.
module apb_seq_ctrl #(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned MEM_ADDR_WIDTH = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                             i_PCLK,
  input  logic                             i_PRESET,
  input  logic                             i_start,
  output logic                             o_busy,
  output logic                             o_halt,
  output logic                             o_err,
  output logic [1:0]                       o_err_code,
  output logic [MEM_ADDR_WIDTH-1:0]        o_cmd_count,
  output logic                             o_mem_en,
  output logic                             o_mem_wr,
  output logic [MEM_ADDR_WIDTH-1:0]        o_mem_addr,
  output logic [DATA_WIDTH-1:0]            o_mem_data_w,
  input  logic [DATA_WIDTH-1:0]            i_mem_data_r,
  output logic [ADDR_WIDTH-1:0]            o_PADDR,
  output logic [NUM_SLAVES-1:0]            o_PSEL,
  output logic                             o_PENABLE,
  output logic                             o_PWRITE,
  output logic [DATA_WIDTH-1:0]            o_PWDATA,
  input  logic [NUM_SLAVES-1:0]            i_PREADY,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] i_PRDATA,
  input  logic [NUM_SLAVES-1:0]            i_PSLVERR
);

  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_F_CTL, S_F_ADR, S_F_DAT, S_DECODE,
    S_SETUP, S_ACCESS, S_WRBACK, S_HALT, S_ERR
  } state_t;

  state_t                    state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] pc_q, pc_d, cnt_q, cnt_d;
  logic                      wr_q, wr_d, hlt_q, hlt_d;
  logic [7:0]                slv_q, slv_d;
  logic [ADDR_WIDTH-1:0]     adr_q, adr_d;
  logic [DATA_WIDTH-1:0]     dat_q, dat_d, rdata_q, rdata_d;
  logic [WAIT_W-1:0]         wait_q, wait_d;
  logic [1:0]                err_code_q, err_code_d;

  logic                      busy_q, busy_d, halt_q, halt_d, err_q, err_d;
  logic                      mem_en_q, mem_en_d, mem_wr_q, mem_wr_d;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
  logic [ADDR_WIDTH-1:0]     paddr_q, paddr_d;
  logic [NUM_SLAVES-1:0]     psel_q, psel_d;
  logic                      penable_q, penable_d, pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]     pwdata_q, pwdata_d;

  logic                      sel_ready, sel_err, bus_on;
  logic [DATA_WIDTH-1:0]     sel_rdata;

  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (32'(slv_q) == k) begin
        sel_ready = i_PREADY[k];
        sel_err   = i_PSLVERR[k];
        sel_rdata = i_PRDATA[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    hlt_d      = hlt_q;
    slv_d      = slv_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    rdata_d    = rdata_q;
    wait_d     = wait_q;
    err_code_d = err_code_q;

    case (state_q)
      S_IDLE, S_HALT, S_ERR: begin
        if (i_start) begin
          pc_d       = '0;
          cnt_d      = '0;
          err_code_d = '0;
          state_d    = S_F_CTL;
        end
      end
      S_F_CTL: state_d = S_F_ADR;
      S_F_ADR: begin
        wr_d    = i_mem_data_r[0];
        hlt_d   = i_mem_data_r[1];
        slv_d   = i_mem_data_r[15:8];
        state_d = S_F_DAT;
      end
      S_F_DAT: begin
        adr_d   = ADDR_WIDTH'(i_mem_data_r);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        dat_d = i_mem_data_r;
        if (hlt_q) begin
          state_d = S_HALT;
        end else if (32'(slv_q) >= NUM_SLAVES) begin
          state_d    = S_ERR;
          err_code_d = 2'd1;
        end else begin
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        wait_d  = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (sel_ready) begin
          if (sel_err) begin
            state_d    = S_ERR;
            err_code_d = 2'd2;
          end else if (!wr_q) begin
            rdata_d = sel_rdata;
            state_d = S_WRBACK;
          end else begin
            pc_d    = pc_q + MEM_ADDR_WIDTH'(3);
            cnt_d   = cnt_q + MEM_ADDR_WIDTH'(1);
            state_d = S_F_CTL;
          end
        end else if (32'(wait_q) == TIMEOUT_CYCLES - 1) begin
          state_d    = S_ERR;
          err_code_d = 2'd3;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WRBACK: begin
        pc_d    = pc_q + MEM_ADDR_WIDTH'(3);
        cnt_d   = cnt_q + MEM_ADDR_WIDTH'(1);
        state_d = S_F_CTL;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copies line up with the state itself.
    busy_d      = !(state_d inside {S_IDLE, S_HALT, S_ERR});
    halt_d      = (state_d == S_HALT);
    err_d       = (state_d == S_ERR);
    mem_en_d    = (state_d inside {S_F_CTL, S_F_ADR, S_F_DAT, S_WRBACK});
    mem_wr_d    = (state_d == S_WRBACK);
    mem_wdata_d = (state_d == S_WRBACK) ? rdata_d : '0;
    case (state_d)
      S_F_CTL:  mem_addr_d = pc_d;
      S_F_ADR:  mem_addr_d = pc_d + MEM_ADDR_WIDTH'(1);
      S_F_DAT:  mem_addr_d = pc_d + MEM_ADDR_WIDTH'(2);
      S_WRBACK: mem_addr_d = MEM_ADDR_WIDTH'(dat_d);
      default:  mem_addr_d = '0;
    endcase

    bus_on    = (state_d inside {S_SETUP, S_ACCESS});
    penable_d = (state_d == S_ACCESS);
    paddr_d   = bus_on ? adr_d : '0;
    pwrite_d  = bus_on & wr_d;
    pwdata_d  = bus_on ? dat_d : '0;
    psel_d    = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      psel_d[k] = bus_on && (32'(slv_d) == k);
    end
  end

  always_ff @(posedge i_PCLK) begin
    if (i_PRESET) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      hlt_q       <= 1'b0;
      slv_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rdata_q     <= '0;
      wait_q      <= '0;
      err_code_q  <= '0;
      busy_q      <= 1'b0;
      halt_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      paddr_q     <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      hlt_q       <= hlt_d;
      slv_q       <= slv_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rdata_q     <= rdata_d;
      wait_q      <= wait_d;
      err_code_q  <= err_code_d;
      busy_q      <= busy_d;
      halt_q      <= halt_d;
      err_q       <= err_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      paddr_q     <= paddr_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
    end
  end

  assign o_busy       = busy_q;
  assign o_halt       = halt_q;
  assign o_err        = err_q;
  assign o_err_code   = err_code_q;
  assign o_cmd_count  = cnt_q;
  assign o_mem_en     = mem_en_q;
  assign o_mem_wr     = mem_wr_q;
  assign o_mem_addr   = mem_addr_q;
  assign o_mem_data_w = mem_wdata_q;
  assign o_PADDR      = paddr_q;
  assign o_PSEL       = psel_q;
  assign o_PENABLE    = penable_q;
  assign o_PWRITE     = pwrite_q;
  assign o_PWDATA     = pwdata_q;

endmodule

// File: tb/tb_apb_seq_ctrl.sv
// Bench for apb_seq_ctrl: memory + slave responders driven from a program-level
// reference model that interprets the command list directly.
module tb_apb_seq_ctrl;

  localparam int unsigned NS = 4;
  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst, start;
  logic        o_busy, o_halt, o_err, o_mem_en, o_mem_wr, o_PENABLE, o_PWRITE;
  logic [1:0]  o_err_code;
  logic [7:0]  o_cmd_count, o_mem_addr;
  logic [15:0] o_mem_data_w, mem_rd, o_PADDR, o_PWDATA;
  logic [3:0]  o_PSEL, pready, pslverr;
  logic [63:0] prdata;

  logic [15:0] mem [256];
  logic        ld_en = 1'b0;
  logic [7:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;

  apb_seq_ctrl #(
    .NUM_SLAVES(NS), .ADDR_WIDTH(16), .DATA_WIDTH(16),
    .MEM_ADDR_WIDTH(8), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_PCLK(clk), .i_PRESET(rst), .i_start(start),
    .o_busy(o_busy), .o_halt(o_halt), .o_err(o_err), .o_err_code(o_err_code),
    .o_cmd_count(o_cmd_count), .o_mem_en(o_mem_en), .o_mem_wr(o_mem_wr),
    .o_mem_addr(o_mem_addr), .o_mem_data_w(o_mem_data_w), .i_mem_data_r(mem_rd),
    .o_PADDR(o_PADDR), .o_PSEL(o_PSEL), .o_PENABLE(o_PENABLE), .o_PWRITE(o_PWRITE),
    .o_PWDATA(o_PWDATA), .i_PREADY(pready), .i_PRDATA(prdata), .i_PSLVERR(pslverr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (o_mem_en) begin
      if (o_mem_wr) mem[o_mem_addr] <= o_mem_data_w;
      else          mem_rd <= mem[o_mem_addr];
    end
  end

  int unsigned n_chk = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  typedef struct {
    int unsigned slv;
    logic [3:0]  psel;
    logic [15:0] addr;
    logic        wr;
    logic [15:0] wdata;
  } txn_t;

  txn_t        exp_q[$];
  logic [15:0] img [256];
  logic [15:0] mdl_mem [256];
  int unsigned wait_a [256];
  bit          err_a [256];
  logic [15:0] rdv_a [256];
  int unsigned exp_busy, exp_cnt, exp_reads;
  bit          exp_halt, exp_err;
  logic [1:0]  exp_code;

  // Interprets the program: per command 4 fetch/decode cycles, then 1 setup and w+1 access cycles, +1 for writeback.
  task automatic model_run();
    int unsigned pc, t, guard;
    logic [15:0] ctl, adr, dat;
    txn_t tx;
    pc = 0; t = 0;
    exp_q.delete();
    exp_busy = 0; exp_cnt = 0; exp_reads = 0;
    exp_halt = 0; exp_err = 0; exp_code = 0;
    for (guard = 0; guard < 1000; guard++) begin
      ctl = mdl_mem[pc];
      adr = mdl_mem[(pc + 1) % 256];
      dat = mdl_mem[(pc + 2) % 256];
      exp_busy += 4;
      if (ctl[1]) begin exp_halt = 1; break; end
      if (ctl[15:8] >= NS) begin exp_err = 1; exp_code = 1; break; end
      tx.slv   = int'(ctl[15:8]);
      tx.psel  = 4'(1 << tx.slv);
      tx.addr  = adr;
      tx.wr    = ctl[0];
      tx.wdata = dat;
      exp_q.push_back(tx);
      if (wait_a[t] >= TO) begin exp_busy += 1 + TO; exp_err = 1; exp_code = 3; break; end
      exp_busy += 2 + wait_a[t];
      if (err_a[t]) begin exp_err = 1; exp_code = 2; break; end
      if (!ctl[0]) begin
        mdl_mem[dat[7:0]] = rdv_a[t];
        exp_reads++;
        exp_busy += 1;
      end
      pc = (pc + 3) % 256;
      exp_cnt = (exp_cnt + 1) % 256;
      t++;
    end
  endtask

  // Slave responders and APB monitor
  int unsigned txn_i = 0, acc_n = 0, wr_pulses = 0;
  logic [3:0]  last_psel = '0;

  always @(negedge clk) begin
    txn_t cur;
    if (o_mem_wr) wr_pulses++;
    pready  = 4'($urandom);
    pslverr = 4'($urandom);
    prdata  = {$urandom, $urandom};
    if (o_PENABLE) begin
      if (txn_i > 0 && txn_i <= exp_q.size()) begin
        cur = exp_q[txn_i-1];
        chk("acc_psel", o_PSEL, cur.psel);
        chk("acc_paddr", o_PADDR, cur.addr);
        pready[cur.slv]  = (acc_n >= wait_a[txn_i-1]);
        pslverr[cur.slv] = pready[cur.slv] ? err_a[txn_i-1] : 1'($urandom);
        if (pready[cur.slv]) prdata[cur.slv*16 +: 16] = rdv_a[txn_i-1];
      end
      acc_n++;
    end else if (|o_PSEL) begin
      if (txn_i < exp_q.size()) begin
        cur = exp_q[txn_i];
        chk("setup_psel", o_PSEL, cur.psel);
        chk("setup_paddr", o_PADDR, cur.addr);
        chk("setup_pwrite", o_PWRITE, cur.wr);
        chk("setup_pwdata", o_PWDATA, cur.wdata);
      end else begin
        chk("extra_txn", txn_i + 1, exp_q.size());
      end
      last_psel = o_PSEL;
      acc_n = 0;
      txn_i++;
    end
  end

  function automatic logic [95:0] all_outs();
    return 96'({o_busy, o_halt, o_err, o_err_code, o_cmd_count, o_mem_en, o_mem_wr,
                o_mem_addr, o_mem_data_w, o_PADDR, o_PSEL, o_PENABLE, o_PWRITE, o_PWDATA});
  endfunction

  task automatic clear_plan();
    for (int i = 0; i < 256; i++) begin
      img[i] = '0; wait_a[i] = 0; err_a[i] = 0; rdv_a[i] = 16'($urandom);
    end
  endtask

  task automatic prep();
    mdl_mem = img;
    model_run();
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_addr = 8'(i); ld_data = img[i];
    end
    @(negedge clk);
    ld_en = 1'b0;
    txn_i = 0; acc_n = 0; wr_pulses = 0;
  endtask

  task automatic run_prog(input string name);
    int unsigned busy_n;
    bit done;
    prep();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_n = 0; done = 0;
    for (int g = 0; g < 4000; g++) begin
      if (!o_busy) begin done = 1; break; end
      busy_n++;
      start = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      start = 1'b0;
    end
    chk({name, ":finished"}, done, 1'b1);
    chk({name, ":busy_cycles"}, busy_n, exp_busy);
    chk({name, ":halt"}, o_halt, exp_halt);
    chk({name, ":err"}, o_err, exp_err);
    chk({name, ":err_code"}, o_err_code, exp_code);
    chk({name, ":cmd_count"}, o_cmd_count, exp_cnt);
    chk({name, ":txn_count"}, txn_i, exp_q.size());
    chk({name, ":wrback_cycles"}, wr_pulses, exp_reads);
    chk({name, ":bus_idle"}, {o_PSEL, o_PENABLE, o_mem_en}, '0);
    for (int i = 0; i < 256; i++) chk($sformatf("%s:mem[%0d]", name, i), mem[i], mdl_mem[i]);
  endtask

  task automatic gen_random();
    int unsigned n, base, slv;
    bit wr;
    n = $urandom_range(1, 6);
    for (int i = 0; i < 256; i++) begin
      img[i]    = 16'($urandom);
      wait_a[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 1, TO + 1) : $urandom_range(0, 3);
      err_a[i]  = ($urandom_range(0, 9) == 0);
      rdv_a[i]  = 16'($urandom);
    end
    for (int c = 0; c < int'(n); c++) begin
      base = c * 3;
      slv  = ($urandom_range(0, 15) == 0) ? $urandom_range(NS, 255) : $urandom_range(0, NS - 1);
      wr   = 1'($urandom);
      img[base]     = {8'(slv), 6'($urandom), 1'b0, wr};
      img[base + 1] = 16'($urandom);
      img[base + 2] = wr ? 16'($urandom) : {8'($urandom), 1'b1, 7'($urandom)};
    end
    img[n * 3] = {8'($urandom), 6'($urandom), 1'b1, 1'($urandom)};
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; pready = '0; pslverr = '0; prdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), '0);
    chk("start_during_reset", o_busy, 1'b0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", all_outs(), '0);

    clear_plan();
    img[0] = 16'h0201; img[1] = 16'h0010; img[2] = 16'hBEEF; img[3] = 16'h0002;
    run_prog("wr_slave2");
    chk("wr_slave2:psel", last_psel, 4'b0100);

    clear_plan();
    img[0] = 16'h0100; img[1] = 16'h0055; img[2] = 16'h0040; img[3] = 16'h0002;
    rdv_a[0] = 16'h1234;
    run_prog("rd_slave1");
    chk("rd_slave1:mem40", mem[8'h40], 16'h1234);

    clear_plan();
    img[0] = 16'h0900;
    run_prog("bad_slave");

    clear_plan();
    img[0] = 16'h0000; img[1] = 16'h0003; img[2] = 16'h0090; img[3] = 16'h0002;
    wait_a[0] = TO;
    run_prog("timeout");
    wait_a[0] = TO - 1;
    run_prog("wait_max");
    img[0] = 16'h0001; wait_a[0] = 0; err_a[0] = 1;
    run_prog("slverr");

    for (int r = 0; r < 30; r++) begin
      gen_random();
      run_prog($sformatf("rand%0d", r));
    end

    clear_plan();
    img[0] = 16'h0201; img[1] = 16'h0777; img[2] = 16'h5A5A; img[3] = 16'h0002;
    wait_a[0] = 10;
    begin
      bit seen;
      prep();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = 0;
      for (int g = 0; g < 50; g++) begin
        if (o_PENABLE) begin seen = 1; break; end
        @(negedge clk);
      end
      chk("rst_mid:reached_access", seen, 1'b1);
      @(negedge clk);
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      chk("rst_mid:outputs", all_outs(), '0);
      @(negedge clk);
      chk("rst_mid:stays_idle", all_outs(), '0);
    end
    wait_a[0] = 0;
    run_prog("rerun");

    clear_plan();
    for (int i = 0; i < 256; i++) img[i] = 16'h0001;
    img[1] = 16'h0002;
    run_prog("wrap");
    chk("wrap:count", o_cmd_count, 8'd171);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
